// File: rtl/spi_cmd_sequencer_if.sv
// Request/serializer-side bundle for spi_cmd_sequencer: two valid/ready request
// channels in, the SPI_Serializer drive signals out.
interface spi_cmd_sequencer_if #(
  parameter int DATA_W = 24
);
  logic              att_valid;
  logic              att_ready;
  logic [DATA_W-1:0] att_data;
  logic              del_valid;
  logic              del_ready;
  logic [DATA_W-1:0] del_data;
  logic [31:0]       Data_Register;
  logic [1:0]        DelAttSelect;
  logic              ld;
  logic              busy;
  logic              done;

  modport master (
    output att_valid, att_data, del_valid, del_data,
    input  att_ready, del_ready, Data_Register, DelAttSelect, ld, busy, done
  );

  modport slave (
    input  att_valid, att_data, del_valid, del_data,
    output att_ready, del_ready, Data_Register, DelAttSelect, ld, busy, done
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Arbitrates attenuator/delay setting requests and paces frames into SPI_Serializer,
// holding each frame for a fixed window since the serializer reports no busy.
module spi_cmd_sequencer #(
  parameter int DATA_W       = 24,
  parameter int SETUP_CYCLES = 4,
  parameter int XFER_CYCLES  = 600,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cmd_sequencer_if.slave   bus
);

  localparam int MAX_AB = (SETUP_CYCLES > XFER_CYCLES) ? SETUP_CYCLES : XFER_CYCLES;
  localparam int MAXC   = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] XFER_LOAD  = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_XFER, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              att_pend_q, att_pend_d;
  logic              del_pend_q, del_pend_d;
  logic [DATA_W-1:0] att_buf_q, att_buf_d;
  logic [DATA_W-1:0] del_buf_q, del_buf_d;
  logic              gnt_del_q, gnt_del_d;
  logic              rr_del_q, rr_del_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic              ld_q, ld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pick_del;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    att_pend_d = att_pend_q;
    del_pend_d = del_pend_q;
    att_buf_d  = att_buf_q;
    del_buf_d  = del_buf_q;
    gnt_del_d  = gnt_del_q;
    rr_del_d   = rr_del_q;
    data_d     = data_q;
    sel_d      = sel_q;
    pick_del   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (att_pend_q || del_pend_q) begin
          // The round-robin pointer only moves when it actually breaks a tie.
          pick_del  = del_pend_q && (!att_pend_q || rr_del_q);
          gnt_del_d = pick_del;
          if (att_pend_q && del_pend_q) rr_del_d = !pick_del;
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
          sel_d   = pick_del ? 2'b10 : 2'b01;
          data_d  = pick_del ? 32'(del_buf_q) : 32'(att_buf_q);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_LOAD;
          if (gnt_del_q) del_pend_d = 1'b0;
          else           att_pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOAD: begin
        state_d = S_XFER;
        cnt_d   = XFER_LOAD;
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          sel_d   = 2'b00;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A full holding register is never the one being cleared, so accept and clear cannot collide.
    if (bus.att_valid && !att_pend_q) begin
      att_pend_d = 1'b1;
      att_buf_d  = bus.att_data;
    end
    if (bus.del_valid && !del_pend_q) begin
      del_pend_d = 1'b1;
      del_buf_d  = bus.del_data;
    end

    ld_d   = (state_d == S_LOAD);
    done_d = (state_d == S_XFER) && (cnt_d == '0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      att_pend_q <= 1'b0;
      del_pend_q <= 1'b0;
      att_buf_q  <= '0;
      del_buf_q  <= '0;
      gnt_del_q  <= 1'b0;
      rr_del_q   <= 1'b0;
      data_q     <= '0;
      sel_q      <= 2'b00;
      ld_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      att_pend_q <= att_pend_d;
      del_pend_q <= del_pend_d;
      att_buf_q  <= att_buf_d;
      del_buf_q  <= del_buf_d;
      gnt_del_q  <= gnt_del_d;
      rr_del_q   <= rr_del_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      ld_q       <= ld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.att_ready     = !att_pend_q;
  assign bus.del_ready     = !del_pend_q;
  assign bus.Data_Register = data_q;
  assign bus.DelAttSelect  = sel_q;
  assign bus.ld            = ld_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: default instance plus a GAP=0/SETUP=1 instance;
// frame contents are scoreboarded and checked at every ld.
module tb_spi_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [33:0] sb_a[$];
  logic [33:0] sb_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_cmd_sequencer_if #(.DATA_W(24)) bus_a();
  spi_cmd_sequencer_if #(.DATA_W(24)) bus_b();

  spi_cmd_sequencer #(.DATA_W(24), .SETUP_CYCLES(4), .XFER_CYCLES(600), .GAP_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  spi_cmd_sequencer #(.DATA_W(24), .SETUP_CYCLES(1), .XFER_CYCLES(20), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Scoreboard: each ld must present the oldest expected frame.
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus_a.ld === 1'b1) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL sb_a_unexpected_ld: got ld=1 sel=%b data=%h, required no ld", bus_a.DelAttSelect, bus_a.Data_Register);
      end else begin
        e = sb_a.pop_front();
        if ({bus_a.DelAttSelect, bus_a.Data_Register} !== e) begin
          n_bad++;
          $display("FAIL sb_a_frame: got sel=%b data=%h, required sel=%b data=%h", bus_a.DelAttSelect, bus_a.Data_Register, e[33:32], e[31:0]);
        end else
          $display("frame A: sel=%b data=%h at cycle %0d", bus_a.DelAttSelect, bus_a.Data_Register, cyc);
      end
    end
    if (bus_b.ld === 1'b1) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL sb_b_unexpected_ld: got ld=1 sel=%b data=%h, required no ld", bus_b.DelAttSelect, bus_b.Data_Register);
      end else begin
        e = sb_b.pop_front();
        if ({bus_b.DelAttSelect, bus_b.Data_Register} !== e) begin
          n_bad++;
          $display("FAIL sb_b_frame: got sel=%b data=%h, required sel=%b data=%h", bus_b.DelAttSelect, bus_b.Data_Register, e[33:32], e[31:0]);
        end else
          $display("frame B: sel=%b data=%h at cycle %0d", bus_b.DelAttSelect, bus_b.Data_Register, cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns the number of negedges until the event, or -1 if the limit expires.
  task automatic wait_ev(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      if (n < 0) begin
        @(negedge clk);
        if ((which == 0 && bus_a.ld === 1'b1) || (which == 1 && bus_a.done === 1'b1) ||
            (which == 2 && bus_a.busy === 1'b0) || (which == 3 && bus_b.ld === 1'b1))
          n = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus_a.Data_Register, bus_a.DelAttSelect, bus_a.ld, bus_a.busy, bus_a.done} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h sel=%b ld=%b busy=%b done=%b, required all 0",
               bus_a.Data_Register, bus_a.DelAttSelect, bus_a.ld, bus_a.busy, bus_a.done);
    end
    n_cmp++;
    if ({bus_a.att_ready, bus_a.del_ready, bus_b.att_ready, bus_b.del_ready} !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_ready: got a=%b%b b=%b%b, required 1111", bus_a.att_ready, bus_a.del_ready, bus_b.att_ready, bus_b.del_ready);
    end
    rst = 1'b0;
    tick();
    $display("test_reset: done, cycle %0d", cyc);
  endtask

  task automatic test_single(input bit use_del, input logic [23:0] d);
    int n;
    logic [1:0] es;
    es = use_del ? 2'b10 : 2'b01;
    if (use_del) begin bus_a.del_valid = 1'b1; bus_a.del_data = d; end
    else         begin bus_a.att_valid = 1'b1; bus_a.att_data = d; end
    sb_a.push_back({es, 8'h00, d});
    tick();
    bus_a.att_valid = 1'b0;
    bus_a.del_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus_a.DelAttSelect !== es || bus_a.Data_Register !== {8'h00, d} || bus_a.busy !== 1'b1 || bus_a.ld !== 1'b0) begin
      n_bad++;
      $display("FAIL single_setup: got sel=%b data=%h busy=%b ld=%b, required sel=%b data=%h busy=1 ld=0",
               bus_a.DelAttSelect, bus_a.Data_Register, bus_a.busy, bus_a.ld, es, {8'h00, d});
    end
    wait_ev(0, 20, n);
    n_cmp++;
    if (n !== 4) begin n_bad++; $display("FAIL single_ld_latency: got %0d, required 4", n); end
    wait_ev(1, 700, n);
    n_cmp++;
    if (n !== 600) begin n_bad++; $display("FAIL single_done_latency: got %0d, required 600", n); end
    tick();
    n_cmp++;
    if (bus_a.DelAttSelect !== 2'b00 || bus_a.busy !== 1'b1 || bus_a.Data_Register !== {8'h00, d}) begin
      n_bad++;
      $display("FAIL single_gap: got sel=%b busy=%b data=%h, required sel=00 busy=1 data=%h", bus_a.DelAttSelect, bus_a.busy, bus_a.Data_Register, {8'h00, d});
    end
    wait_ev(2, 20, n);
    n_cmp++;
    if (n !== 8) begin n_bad++; $display("FAIL single_busy_low: got %0d, required 8", n); end
    $display("test_single: del=%0d data=%h done, cycle %0d", use_del, d, cyc);
  endtask

  task automatic test_tie();
    int n, c0;
    for (int pass = 0; pass < 2; pass++) begin
      bus_a.att_valid = 1'b1; bus_a.att_data = 24'h111111 + 24'(pass);
      bus_a.del_valid = 1'b1; bus_a.del_data = 24'h222222 + 24'(pass);
      if (pass == 0) begin
        sb_a.push_back({2'b01, 8'h00, 24'h111111});
        sb_a.push_back({2'b10, 8'h00, 24'h222222});
      end else begin
        sb_a.push_back({2'b10, 8'h00, 24'h222223});
        sb_a.push_back({2'b01, 8'h00, 24'h111112});
      end
      tick();
      bus_a.att_valid = 1'b0;
      bus_a.del_valid = 1'b0;
      wait_ev(0, 20, n);
      n_cmp++;
      if (n !== 5) begin n_bad++; $display("FAIL tie_first_ld: got %0d, required 5", n); end
      c0 = cyc;
      wait_ev(0, 700, n);
      n_cmp++;
      if (n < 0 || cyc - c0 !== 614) begin
        n_bad++;
        $display("FAIL tie_ld_spacing: got %0d, required 614", (n < 0) ? -1 : cyc - c0);
      end
      wait_ev(2, 700, n);
      $display("test_tie: pass %0d done, cycle %0d", pass, cyc);
    end
  endtask

  task automatic test_queue();
    int n;
    bus_a.att_valid = 1'b1; bus_a.att_data = 24'h0A0B0C;
    sb_a.push_back({2'b01, 8'h00, 24'h0A0B0C});
    tick();
    bus_a.att_valid = 1'b0;
    wait_ev(0, 20, n);
    repeat (10) tick();
    n_cmp++;
    if (bus_a.att_ready !== 1'b1) begin n_bad++; $display("FAIL queue_ready_before: got %b, required 1", bus_a.att_ready); end
    bus_a.att_valid = 1'b1; bus_a.att_data = 24'h123456;
    sb_a.push_back({2'b01, 8'h00, 24'h123456});
    tick();
    bus_a.att_valid = 1'b1; bus_a.att_data = 24'hBADBAD;
    n_cmp++;
    if (bus_a.att_ready !== 1'b0) begin n_bad++; $display("FAIL queue_ready_held: got %b, required 0", bus_a.att_ready); end
    tick();
    bus_a.att_valid = 1'b0;
    wait_ev(1, 700, n);
    wait_ev(2, 20, n);
    n_cmp++;
    if (n !== 9 || bus_a.att_ready !== 1'b0 || bus_a.ld !== 1'b0) begin
      n_bad++;
      $display("FAIL queue_idle: got n=%0d ready=%b ld=%b, required n=9 ready=0 ld=0", n, bus_a.att_ready, bus_a.ld);
    end
    wait_ev(0, 20, n);
    n_cmp++;
    if (n !== 5 || bus_a.att_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL queue_load: got n=%0d ready=%b, required n=5 ready=1", n, bus_a.att_ready);
    end
    wait_ev(2, 700, n);
    repeat (20) tick();
    n_cmp++;
    if (bus_a.busy !== 1'b0 || sb_a.size() != 0) begin
      n_bad++;
      $display("FAIL queue_third_dropped: got busy=%b pending_frames=%0d, required busy=0 pending_frames=0", bus_a.busy, sb_a.size());
    end
    $display("test_queue: done, cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int n, dones, lds;
    bus_a.att_valid = 1'b1; bus_a.att_data = 24'h777777;
    sb_a.push_back({2'b01, 8'h00, 24'h777777});
    tick();
    bus_a.att_valid = 1'b0;
    wait_ev(0, 20, n);
    repeat (5) tick();
    bus_a.del_valid = 1'b1; bus_a.del_data = 24'h333333;
    tick();
    bus_a.del_valid = 1'b0;
    n_cmp++;
    if (bus_a.del_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_del_held: got %b, required 0", bus_a.del_ready); end
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus_a.Data_Register, bus_a.DelAttSelect, bus_a.ld, bus_a.busy, bus_a.done} !== 37'd0 ||
        bus_a.att_ready !== 1'b1 || bus_a.del_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got data=%h sel=%b ld=%b busy=%b done=%b ready=%b%b, required zeros ready=11",
               bus_a.Data_Register, bus_a.DelAttSelect, bus_a.ld, bus_a.busy, bus_a.done, bus_a.att_ready, bus_a.del_ready);
    end
    dones = 0; lds = 0;
    repeat (700) begin
      tick();
      if (bus_a.done === 1'b1) dones++;
      if (bus_a.ld === 1'b1 || bus_a.busy === 1'b1) lds++;
    end
    n_cmp++;
    if (dones != 0 || lds != 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got done=%0d ld/busy=%0d, required 0 and 0", dones, lds);
    end
    $display("test_reset_mid: done, cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int n, k, z, bad00;
    bit got;
    bus_b.att_valid = 1'b1; bus_b.att_data = 24'hA5A5A5;
    bus_b.del_valid = 1'b1; bus_b.del_data = 24'h5A5A5A;
    sb_b.push_back({2'b01, 8'h00, 24'hA5A5A5});
    sb_b.push_back({2'b10, 8'h00, 24'h5A5A5A});
    tick();
    bus_b.att_valid = 1'b0;
    bus_b.del_valid = 1'b0;
    wait_ev(3, 20, n);
    n_cmp++;
    if (n !== 2) begin n_bad++; $display("FAIL b2b_first_ld: got %0d, required 2", n); end
    k = 0; z = 0; bad00 = 0; got = 1'b0;
    while (!got && k < 40) begin
      tick();
      k++;
      if (bus_b.ld === 1'b1) got = 1'b1;
      else if (bus_b.DelAttSelect === 2'b00) begin
        z++;
        if (bus_b.busy === 1'b1) bad00++;
      end
    end
    n_cmp++;
    if (!got || k != 23) begin n_bad++; $display("FAIL b2b_ld_spacing: got %0d, required 23", got ? k : -1); end
    n_cmp++;
    if (z != 1 || bad00 != 0) begin
      n_bad++;
      $display("FAIL b2b_sel_zero: got zero_cycles=%0d zero_while_busy=%0d, required 1 and 0", z, bad00);
    end
    repeat (30) tick();
    n_cmp++;
    if (bus_b.busy !== 1'b0 || sb_b.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got busy=%b pending_frames=%0d, required busy=0 pending_frames=0", bus_b.busy, sb_b.size());
    end
    $display("test_back_to_back: done, cycle %0d", cyc);
  endtask

  initial begin
    bus_a.att_valid = 1'b0; bus_a.att_data = '0; bus_a.del_valid = 1'b0; bus_a.del_data = '0;
    bus_b.att_valid = 1'b0; bus_b.att_data = '0; bus_b.del_valid = 1'b0; bus_b.del_data = '0;
    test_reset();
    test_single(1'b0, 24'h9E6D55);
    test_single(1'b1, 24'h80F0FE);
    test_tie();
    test_queue();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (sb_a.size() != 0) begin n_bad++; $display("FAIL sb_a_leftover: got %0d frames, required 0", sb_a.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
